// File: rtl/eoc_hit_buffer.sv
// End-of-column hit buffer: drops null arbiter words, tags the rest with the column address, FWFT FIFO.
// Latency: a word accepted at edge N is at the head (out_valid=1) right after edge N when the FIFO was empty.
// Backpressure: shake_hands_next=0 while full (registered level only); periphery drains via out_valid/out_ready.
//
// Ports:
//   clk_40MHz, rst_n           - clock, asynchronous active-low reset
//   addr_col                   - static column address, tagged onto each stored word
//   arbiter_data               - 26-bit hit word {TOA, FTOA, TOT, pixel id}
//   shake_hands_last/next      - chain handshake in (valid) / out (ready)
//   out_data/valid/ready       - FIFO head {addr_col, arbiter_data} with valid/ready drain
//   cnt_clr, hit_cnt           - synchronous clear / saturating count of stored words
//   fifo_level                 - current occupancy
module eoc_hit_buffer #(
  parameter int DEPTH      = 8,
  parameter int COL_ADDR_W = 5
) (
  input  logic                        clk_40MHz,
  input  logic                        rst_n,
  input  logic [COL_ADDR_W-1:0]       addr_col,
  input  logic [25:0]                 arbiter_data,
  input  logic                        shake_hands_last,
  output logic                        shake_hands_next,
  output logic [26+COL_ADDR_W-1:0]    out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        cnt_clr,
  output logic [15:0]                 hit_cnt,
  output logic [$clog2(DEPTH):0]      fifo_level
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int WORD_W = 26 + COL_ADDR_W;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [15:0]       hit_cnt_q, hit_cnt_d;

  logic in_xfer;
  logic wr_en;
  logic rd_en;

  // Ready comes purely from the registered level, so the chain never sees a
  // combinational path from its own valid back to ready.
  assign shake_hands_next = (level_q != FULL_LVL);
  assign out_valid        = (level_q != '0);
  assign out_data         = mem_q[rd_ptr_q];
  assign hit_cnt          = hit_cnt_q;
  assign fifo_level       = level_q;

  // A null word still completes the handshake (releases the chain) but is not stored.
  assign in_xfer = shake_hands_last && shake_hands_next;
  assign wr_en   = in_xfer && (arbiter_data != 26'h0);
  assign rd_en   = out_valid && out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    hit_cnt_d = hit_cnt_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Clear wins over a same-cycle increment.
    if (cnt_clr) begin
      hit_cnt_d = 16'h0;
    end else if (wr_en && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'h1;
    end
  end

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      hit_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  // Gating with rst_n keeps a word presented during reset out of the array.
  always_ff @(posedge clk_40MHz) begin
    if (wr_en && rst_n) begin
      mem_q[wr_ptr_q] <= {addr_col, arbiter_data};
    end
  end

endmodule

// File: tb/tb_eoc_hit_buffer.sv
module tb_eoc_hit_buffer;

  localparam int DEPTH      = 8;
  localparam int COL_ADDR_W = 5;

  logic        clk_40MHz = 1'b0;
  logic        rst_n;
  logic [4:0]  addr_col;
  logic [25:0] arbiter_data;
  logic        shake_hands_last;
  logic        shake_hands_next;
  logic [30:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [15:0] hit_cnt;
  logic [3:0]  fifo_level;

  int n_chk  = 0;
  int n_fail = 0;

  eoc_hit_buffer #(.DEPTH(DEPTH), .COL_ADDR_W(COL_ADDR_W)) dut (
    .clk_40MHz        (clk_40MHz),
    .rst_n            (rst_n),
    .addr_col         (addr_col),
    .arbiter_data     (arbiter_data),
    .shake_hands_last (shake_hands_last),
    .shake_hands_next (shake_hands_next),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .cnt_clr          (cnt_clr),
    .hit_cnt          (hit_cnt),
    .fifo_level       (fifo_level)
  );

  always #5 clk_40MHz = ~clk_40MHz;

  typedef struct {
    logic        vld;
    logic [25:0] dat;
    logic        rdy;
    logic        clr;
    logic        e_vld;
    logic [25:0] e_dat;
    logic [3:0]  e_lvl;
    logic [15:0] e_cnt;
    logic        e_shn;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 ns after the rising edge.
  task automatic tick();
    @(posedge clk_40MHz);
    #2;
  endtask

  task automatic chk_head(input string name, input logic [25:0] exp_dat);
    chk({name, "_vld"}, 32'(out_valid), 32'(1'b1));
    chk({name, "_dat"}, 32'(out_data), 32'({5'd3, exp_dat}));
  endtask

  initial begin
    // vld, dat, rdy, clr | e_vld, e_dat, e_lvl, e_cnt, e_shn
    vecs[0] = '{1'b1, 26'h0,       1'b0, 1'b0, 1'b0, 26'h0,       4'd0, 16'd0, 1'b1}; // null word, empty
    vecs[1] = '{1'b1, 26'h1A2B3C4, 1'b0, 1'b0, 1'b1, 26'h1A2B3C4, 4'd1, 16'd1, 1'b1}; // single hit
    vecs[2] = '{1'b0, 26'h0,       1'b1, 1'b0, 1'b0, 26'h0,       4'd0, 16'd1, 1'b1}; // drain it
    vecs[3] = '{1'b1, 26'h0000055, 1'b0, 1'b0, 1'b1, 26'h0000055, 4'd1, 16'd2, 1'b1};
    vecs[4] = '{1'b1, 26'h3FFFFFF, 1'b1, 1'b0, 1'b1, 26'h3FFFFFF, 4'd1, 16'd3, 1'b1}; // write+read
    vecs[5] = '{1'b1, 26'h0,       1'b1, 1'b1, 1'b0, 26'h0,       4'd0, 16'd0, 1'b1}; // null+read, clr
    vecs[6] = '{1'b1, 26'h2AAAAAA, 1'b0, 1'b1, 1'b1, 26'h2AAAAAA, 4'd1, 16'd0, 1'b1}; // clr beats write
    vecs[7] = '{1'b0, 26'h0,       1'b1, 1'b0, 1'b0, 26'h0,       4'd0, 16'd0, 1'b1};

    rst_n            = 1'b0;
    addr_col         = 5'd3;
    arbiter_data     = 26'h0;
    shake_hands_last = 1'b0;
    out_ready        = 1'b0;
    cnt_clr          = 1'b0;
    #12;
    chk("rst_vld", 32'(out_valid), 32'(1'b0));
    chk("rst_lvl", 32'(fifo_level), 32'(4'd0));
    chk("rst_shn", 32'(shake_hands_next), 32'(1'b1));
    chk("rst_cnt", 32'(hit_cnt), 32'(16'd0));
    @(negedge clk_40MHz);
    rst_n = 1'b1;
    tick();

    // Table-driven single-cycle vectors
    for (int i = 0; i < 8; i++) begin
      shake_hands_last = vecs[i].vld;
      arbiter_data     = vecs[i].dat;
      out_ready        = vecs[i].rdy;
      cnt_clr          = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_vld", i), 32'(out_valid), 32'(vecs[i].e_vld));
      chk($sformatf("vec%0d_lvl", i), 32'(fifo_level), 32'(vecs[i].e_lvl));
      chk($sformatf("vec%0d_cnt", i), 32'(hit_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_shn", i), 32'(shake_hands_next), 32'(vecs[i].e_shn));
      if (vecs[i].e_vld)
        chk($sformatf("vec%0d_dat", i), 32'(out_data), 32'({5'd3, vecs[i].e_dat}));
    end
    shake_hands_last = 1'b0;
    out_ready        = 1'b0;
    cnt_clr          = 1'b0;

    // Fill and backpressure
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("fill%0d_shn", i), 32'(shake_hands_next), 32'(1'b1));
      shake_hands_last = 1'b1;
      arbiter_data     = 26'(i);
      tick();
    end
    chk("full_shn", 32'(shake_hands_next), 32'(1'b0));
    chk("full_lvl", 32'(fifo_level), 32'(4'd8));
    arbiter_data = 26'd9;
    tick();
    tick();
    chk("held_lvl", 32'(fifo_level), 32'(4'd8));
    chk("held_shn", 32'(shake_hands_next), 32'(1'b0));
    chk_head("held_head", 26'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rd_full_lvl", 32'(fifo_level), 32'(4'd7));
    chk("rd_full_shn", 32'(shake_hands_next), 32'(1'b1));
    chk_head("rd_full_head", 26'd2);
    tick();
    shake_hands_last = 1'b0;
    chk("w9_lvl", 32'(fifo_level), 32'(4'd8));
    chk("w9_shn", 32'(shake_hands_next), 32'(1'b0));
    chk("w9_cnt", 32'(hit_cnt), 32'(16'd9));
    out_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      chk_head($sformatf("drain%0d", k), 26'(k));
      tick();
    end
    out_ready = 1'b0;
    chk("drained_vld", 32'(out_valid), 32'(1'b0));
    chk("drained_lvl", 32'(fifo_level), 32'(4'd0));

    // Streaming
    cnt_clr = 1'b1;
    tick();
    cnt_clr          = 1'b0;
    shake_hands_last = 1'b1;
    out_ready        = 1'b1;
    for (int i = 0; i < 20; i++) begin
      arbiter_data = 26'(100 + i);
      tick();
      chk($sformatf("strm%0d_lvl", i), 32'(fifo_level), 32'(4'd1));
      chk_head($sformatf("strm%0d", i), 26'(100 + i));
    end
    chk("strm_cnt", 32'(hit_cnt), 32'(16'd20));
    shake_hands_last = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("strm_end_vld", 32'(out_valid), 32'(1'b0));

    // Counter saturation and clear
    force dut.hit_cnt_q = 16'hFFFE;
    #1;
    release dut.hit_cnt_q;
    chk("sat_pre", 32'(hit_cnt), 32'(16'hFFFE));
    shake_hands_last = 1'b1;
    out_ready        = 1'b1;
    arbiter_data     = 26'h7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat%0d_cnt", i), 32'(hit_cnt), 32'(16'hFFFF));
    end
    cnt_clr = 1'b1;
    tick();
    chk("clr_wr_cnt", 32'(hit_cnt), 32'(16'h0));
    cnt_clr          = 1'b0;
    shake_hands_last = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("sat_end_lvl", 32'(fifo_level), 32'(4'd0));

    // Async reset mid-operation
    shake_hands_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      arbiter_data = 26'(200 + i);
      tick();
    end
    shake_hands_last = 1'b0;
    chk("pre_rst_lvl", 32'(fifo_level), 32'(4'd5));
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(out_valid), 32'(1'b0));
    chk("arst_lvl", 32'(fifo_level), 32'(4'd0));
    chk("arst_shn", 32'(shake_hands_next), 32'(1'b1));
    chk("arst_cnt", 32'(hit_cnt), 32'(16'd0));
    shake_hands_last = 1'b1;
    arbiter_data     = 26'h77;
    tick();
    chk("in_rst_lvl", 32'(fifo_level), 32'(4'd0));
    #1;
    rst_n        = 1'b1;
    arbiter_data = 26'h0BEEF01;
    tick();
    shake_hands_last = 1'b0;
    chk_head("post_rst", 26'h0BEEF01);
    chk("post_rst_lvl", 32'(fifo_level), 32'(4'd1));
    chk("post_rst_cnt", 32'(hit_cnt), 32'(16'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eoc_hit_buffer.md
# eoc_hit_buffer

End-of-column hit buffer sitting directly downstream of the topmost `top_single_super_pixel` in a column daisy chain. It accepts 26-bit arbiter words (TOA[25:17], FTOA[16:12], TOT[11:4], pixel id[3:0]) through the chain handshake. It discards null words, tags each accepted word with the column address and queues it in a first-word-fall-through FIFO. The periphery readout drains the FIFO through a valid/ready port.

## Interface
- `DEPTH`, 8, FIFO depth in words; power of two, at least 2.
- `COL_ADDR_W`, 5, column address width.
- `clk_40MHz`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `addr_col`  in  COL_ADDR_W  static column address, sampled on each write.
- `arbiter_data`  in  26  hit word from the column chain.
- `shake_hands_last`  in  1  chain has a word on `arbiter_data` (valid).
- `shake_hands_next`  out  1  buffer can accept a word (ready); drives the chain's `shake_hands_next`.
- `out_data`  out  26+COL_ADDR_W  {addr_col, arbiter_data} at FIFO head.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  periphery consumes the head word.
- `cnt_clr`  in  1  synchronous clear of `hit_cnt`.
- `hit_cnt`  out  16  saturating count of words written.
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage is a DEPTH×(26+COL_ADDR_W) register array with write and read pointers of $clog2(DEPTH) bits that wrap naturally, plus an occupancy counter of $clog2(DEPTH)+1 bits.
- `shake_hands_next` = (level != DEPTH). It is derived only from registered state and never depends on `shake_hands_last` in the same cycle.
- Input transfer: `shake_hands_last` && `shake_hands_next` at a rising edge.
  - Nonzero `arbiter_data`: write {addr_col, arbiter_data} at the write pointer, then increment the write pointer.
  - `arbiter_data` == 0: handshake completes (chain is released) but nothing is written and the pointer does not move.
- Output transfer: `out_valid` && `out_ready` at a rising edge; the read pointer increments.
- `out_data` is combinational from mem[rd_ptr]. When `out_valid`=0, `out_data` holds the value at mem[rd_ptr] and is don't-care for checking.
- Level update: +1 on write only, −1 on read only, unchanged on simultaneous write and read.
- Simultaneous write and read:
  - When level == DEPTH, `shake_hands_next`=0, so no write occurs even if a read drains a word that same edge. Ready reasserts the following cycle.
  - When level == 0, no read is possible, so a write goes in alone.
- `hit_cnt` increments on each nonzero write and saturates at 16'hFFFF. `cnt_clr` takes priority over an increment in the same cycle; the result is 0.
- Reset (asynchronous, at any time, including mid-transfer):
  - Pointers, level and `hit_cnt` go to 0, `out_valid`=0 and `shake_hands_next`=1.
  - Memory contents are not reset.
  - A word presented during reset is not captured.

## Timing
- Write latency: a word accepted at edge N is visible on `out_data` with `out_valid`=1 after edge N, when the FIFO was empty.
- Read: after a consuming edge, the next word (or `out_valid`=0) is visible after that same edge.
- `shake_hands_next` falls after the edge that makes level == DEPTH. It rises after the first edge with a read and no write while full.
- Sustained throughput is one word per clock when both sides are continuously valid/ready and level < DEPTH.
- `hit_cnt` and `fifo_level` update on the same edge as the transfer that causes them.
- Reset release is asynchronous to the clock edge. The first accepted transfer is on the first rising edge with `rst_n`=1.

## Test plan
- Single hit: `addr_col`=5'd3; present 26'h1A2B3C4 with valid for one cycle; `out_ready`=0.
  - Required: `out_valid`=1 next cycle, `out_data`={5'd3, 26'h1A2B3C4}, `fifo_level`=1, `hit_cnt`=1.
- Null word: present `arbiter_data`=0 with valid.
  - Required: `shake_hands_next` stays 1, `fifo_level` and `hit_cnt` unchanged, `out_valid` stays 0.
- Fill and backpressure: `out_ready`=0; push words 1..9 back-to-back.
  - Required: words 1..8 are accepted and `shake_hands_next`=0 after the 8th.
  - Required: word 9 is held until one `out_ready` pulse; word 9 is written the cycle after the read.
  - Required: drain order is 1..9.
- Streaming: valid and `out_ready` both high for 20 cycles with incrementing data.
  - Required: `fifo_level` stays at 1 after the first cycle, output order matches input order, `hit_cnt`=20.
- Counter saturation and clear: force `hit_cnt` to 16'hFFFE, write 3 words.
  - Required: `hit_cnt` reads FFFF.
  - Required: `cnt_clr` asserted in the same cycle as a write gives 0.
- Async reset mid-operation: with level=5, pull `rst_n` low between clock edges.
  - Required: `out_valid`=0, `fifo_level`=0 and `shake_hands_next`=1 immediately, without waiting for an edge.
  - Required: after release, the first pushed word appears at the head.
